// File: rtl/cluster_rate_meter_pkg.sv
// Shared types and elaboration-time helpers for the cluster rate meter.
// Provides the output-pipeline FSM state enum, the window-length derivation
// and the decade threshold table used by the log bar encoder.
package cluster_rate_pkg;

    typedef enum logic [1:0] {
        ST_COUNT  = 2'd0,
        ST_SCALE  = 2'd1,
        ST_ENCODE = 2'd2
    } meter_state_t;

    // Marker for a threshold outside the rate range; a rate narrower than
    // 64 bits can never reach it.
    localparam logic [63:0] NEVER_MET = {64{1'b1}};

    // Measurement window length in clocks.
    function automatic int unsigned window_len(input int unsigned clk_freq,
                                               input int unsigned speedup);
        return clk_freq >> speedup;
    endfunction

    // Threshold T[k] = 10^k, or NEVER_MET when 10^k does not fit in
    // count_width bits.
    function automatic logic [63:0] threshold(input int k, input int count_width);
        logic [63:0] lim;
        logic [63:0] t;
        logic        over;
        lim  = (count_width >= 64) ? {64{1'b1}} : ((64'd1 << count_width) - 64'd1);
        t    = 64'd1;
        over = 1'b0;
        for (int i = 0; i < k; i++) begin
            if (t > lim / 64'd10) over = 1'b1;
            else                  t    = t * 64'd10;
        end
        threshold = (over || (t > lim)) ? NEVER_MET : t;
    endfunction

endpackage

// File: rtl/cluster_rate_meter_if.sv
// Cluster count in, rate / log bar out, between cluster packer and LED controller.
// Ports: ttc_resync, increment_i (packer -> meter); rate_o, rate_valid_o, bar_o (meter -> LEDs/regs).
// No backpressure: the count is consumed every clock and the outputs are level/pulse signals.
interface cluster_rate_meter_if #(
    parameter int COUNT_WIDTH = 32,
    parameter int INC_WIDTH   = 8,
    parameter int BAR_WIDTH   = 8
);
    logic                   ttc_resync;
    logic [INC_WIDTH-1:0]   increment_i;
    logic [COUNT_WIDTH-1:0] rate_o;
    logic                   rate_valid_o;
    logic [BAR_WIDTH-1:0]   bar_o;

    // master: the side producing cluster counts and consuming the rate
    modport master (
        output ttc_resync,
        output increment_i,
        input  rate_o,
        input  rate_valid_o,
        input  bar_o
    );

    // slave: the rate meter itself
    modport slave (
        input  ttc_resync,
        input  increment_i,
        output rate_o,
        output rate_valid_o,
        output bar_o
    );
endinterface

// File: rtl/cluster_rate_meter_log_bar_encoder.sv
// Rate -> decade level -> thermometer bar, registered; optional peak hold with decay.
// Ports: clock, reset (sync, active-low), en (update strobe), rate (in), bar (out).
// Latency 1 cycle from en; no backpressure. Peak hold: CLUSTER_RATE_METER_PEAK_HOLD_EN.
module log_bar_encoder
    import cluster_rate_pkg::*;
#(
    parameter int COUNT_WIDTH   = 32,
    parameter int BAR_WIDTH     = 8,
    parameter int DECAY_WINDOWS = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   en,
    input  logic [COUNT_WIDTH-1:0] rate,
    output logic [BAR_WIDTH-1:0]   bar
);
    localparam int LVL_W = $clog2(BAR_WIDTH + 1);

    if (DECAY_WINDOWS < 1) begin : g_bad_decay
        $error("DECAY_WINDOWS must be at least 1");
    end

    logic [LVL_W-1:0] level;

    // Count how many decade thresholds the rate reaches.
    always_comb begin
        level = '0;
        for (int k = 0; k < BAR_WIDTH; k++) begin
            if (64'(rate) >= threshold(k, COUNT_WIDTH)) level = level + LVL_W'(1);
        end
    end

    function automatic logic [BAR_WIDTH-1:0] therm(input logic [LVL_W-1:0] n);
        therm = '0;
        for (int i = 0; i < BAR_WIDTH; i++) begin
            if (i < int'(n)) therm[i] = 1'b1;
        end
    endfunction

`ifdef CLUSTER_RATE_METER_PEAK_HOLD_EN
    localparam int DEC_W = $clog2(DECAY_WINDOWS + 1);

    logic [LVL_W-1:0] peak;
    logic [LVL_W-1:0] peak_dec;
    logic [DEC_W-1:0] decay_cnt;

    // One segment down, but never below the live level. Only used when
    // level < peak, so peak is at least 1 here.
    assign peak_dec = ((peak - LVL_W'(1)) > level) ? (peak - LVL_W'(1)) : level;

    always_ff @(posedge clock) begin
        if (!reset) begin
            peak      <= '0;
            decay_cnt <= '0;
            bar       <= '0;
        end else if (en) begin
            if (level >= peak) begin
                peak      <= level;
                decay_cnt <= '0;
                bar       <= therm(level);
            end else if (decay_cnt == DEC_W'(DECAY_WINDOWS - 1)) begin
                peak      <= peak_dec;
                decay_cnt <= '0;
                bar       <= therm(peak_dec);
            end else begin
                decay_cnt <= decay_cnt + DEC_W'(1);
            end
        end
    end
`else
    always_ff @(posedge clock) begin
        if (!reset) begin
            bar <= '0;
        end else if (en) begin
            bar <= therm(level);
        end
    end
`endif

endmodule

// File: rtl/cluster_rate_meter.sv
// Windowed S-bit cluster rate meter: saturating Hz figure plus log LED bar.
// Ports: clock, reset (sync, active-low), bus (slave: resync/increment in, rate/valid/bar out).
// rate_o 1 cycle and bar_o 2 cycles after window end; no backpressure. Option: CLUSTER_RATE_METER_PEAK_HOLD_EN.
module cluster_rate_meter
    import cluster_rate_pkg::*;
#(
    parameter int unsigned CLK_FREQUENCY  = 40079000,
    parameter int unsigned SPEEDUP_FACTOR = 4,
    parameter int          COUNT_WIDTH    = 32,
    parameter int          INC_WIDTH      = 8,
    parameter int          BAR_WIDTH      = 8,
    parameter int          DECAY_WINDOWS  = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    cluster_rate_meter_if.slave  bus
);
    localparam int unsigned      WINDOW   = window_len(CLK_FREQUENCY, SPEEDUP_FACTOR);
    localparam int               WIN_W    = $clog2(WINDOW);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

    if (WINDOW < 3) begin : g_bad_window
        $error("measurement window must be at least 3 clocks");
    end
    if (SPEEDUP_FACTOR >= COUNT_WIDTH) begin : g_bad_speedup
        $error("SPEEDUP_FACTOR must be smaller than COUNT_WIDTH");
    end

    meter_state_t               state;
    meter_state_t               state_nxt;
    logic [WIN_W-1:0]           win_cnt;
    logic [COUNT_WIDTH-1:0]     acc;
    logic [COUNT_WIDTH-1:0]     snapshot;
    logic [COUNT_WIDTH-1:0]     rate_q;
    logic                       rate_vld_q;
    logic [BAR_WIDTH-1:0]       bar_q;
    logic [COUNT_WIDTH:0]       acc_sum;
    logic [COUNT_WIDTH-1:0]     acc_sat;
    logic [2*COUNT_WIDTH-1:0]   shifted;
    logic [COUNT_WIDTH-1:0]     rate_sat;
    logic                       window_end;
    logic                       load_rate;
    logic                       encode_en;

    // Extra carry bit detects accumulator overflow; clamp instead of wrap.
    assign acc_sum  = {1'b0, acc} + (COUNT_WIDTH + 1)'(bus.increment_i);
    assign acc_sat  = acc_sum[COUNT_WIDTH] ? '1 : acc_sum[COUNT_WIDTH-1:0];

    // A resync in the last window cycle discards the window: no snapshot.
    assign window_end = (win_cnt == WIN_LAST) && !bus.ttc_resync;

    // Scale to Hz; any bit pushed past the top clamps to full scale.
    assign shifted  = (2 * COUNT_WIDTH)'(snapshot) << SPEEDUP_FACTOR;
    assign rate_sat = (|shifted[2*COUNT_WIDTH-1:COUNT_WIDTH]) ? '1 : shifted[COUNT_WIDTH-1:0];

    // Window counter and accumulator run regardless of the output FSM.
    always_ff @(posedge clock) begin
        if (!reset) begin
            win_cnt  <= '0;
            acc      <= '0;
            snapshot <= '0;
        end else if (bus.ttc_resync) begin
            win_cnt  <= '0;
            acc      <= '0;
        end else if (win_cnt == WIN_LAST) begin
            win_cnt  <= '0;
            acc      <= '0;
            snapshot <= acc_sat;
        end else begin
            win_cnt  <= win_cnt + WIN_W'(1);
            acc      <= acc_sat;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) state <= ST_COUNT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_rate = 1'b0;
        encode_en = 1'b0;
        case (state)
            ST_COUNT: begin
                if (window_end) state_nxt = ST_SCALE;
            end
            ST_SCALE: begin
                load_rate = 1'b1;
                state_nxt = ST_ENCODE;
            end
            ST_ENCODE: begin
                encode_en = 1'b1;
                state_nxt = ST_COUNT;
            end
            default: state_nxt = ST_COUNT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rate_q     <= '0;
            rate_vld_q <= 1'b0;
        end else begin
            rate_vld_q <= load_rate;
            if (load_rate) rate_q <= rate_sat;
        end
    end

    log_bar_encoder #(
        .COUNT_WIDTH   (COUNT_WIDTH),
        .BAR_WIDTH     (BAR_WIDTH),
        .DECAY_WINDOWS (DECAY_WINDOWS)
    ) u_encoder (
        .clock (clock),
        .reset (reset),
        .en    (encode_en),
        .rate  (rate_q),
        .bar   (bar_q)
    );

    assign bus.rate_o       = rate_q;
    assign bus.rate_valid_o = rate_vld_q;
    assign bus.bar_o        = bar_q;

endmodule

// File: tb/tb_cluster_rate_meter.sv
// Bench for cluster_rate_meter: 32-bit and 16-bit instances driven in parallel.
// A window-level model (sums, decades, peak rules) is compared every cycle,
// plus literal expectations for latency, rates, bars and the decay sequence.
module tb_cluster_rate_meter;
    localparam int WINDOW = 100;
    localparam int DW     = 2;

    logic       clk    = 1'b0;
    logic       rst    = 1'b0;
    logic       resync = 1'b0;
    logic [7:0] inc    = 8'd0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cluster_rate_meter_if #(.COUNT_WIDTH(32), .INC_WIDTH(8), .BAR_WIDTH(8)) if32 ();
    cluster_rate_meter_if #(.COUNT_WIDTH(16), .INC_WIDTH(8), .BAR_WIDTH(8)) if16 ();

    assign if32.increment_i = inc;
    assign if32.ttc_resync  = resync;
    assign if16.increment_i = inc;
    assign if16.ttc_resync  = resync;

    cluster_rate_meter #(
        .CLK_FREQUENCY(1600), .SPEEDUP_FACTOR(4), .COUNT_WIDTH(32),
        .INC_WIDTH(8), .BAR_WIDTH(8), .DECAY_WINDOWS(DW)
    ) dut32 (.clock(clk), .reset(rst), .bus(if32));

    cluster_rate_meter #(
        .CLK_FREQUENCY(1600), .SPEEDUP_FACTOR(4), .COUNT_WIDTH(16),
        .INC_WIDTH(8), .BAR_WIDTH(8), .DECAY_WINDOWS(DW)
    ) dut16 (.clock(clk), .reset(rst), .bus(if16));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int               cws [2] = '{32, 16};
    bit               started = 1'b0;
    int               pos;
    longint unsigned  wsum, snap;
    bit               pend_s, pend_e;
    longint unsigned  m_rate [2];
    bit               m_vld;
    int               m_show [2];
    int               peak [2];
    int               dec [2];

    function automatic longint unsigned full_scale(input int cw);
        return (64'd1 << cw) - 64'd1;
    endfunction

    function automatic int level_of(input longint unsigned r, input int cw);
        longint unsigned t = 1;
        int n = 0;
        for (int k = 0; k < 8; k++) begin
            if (t <= full_scale(cw) && r >= t) n++;
            t = t * 10;
        end
        return n;
    endfunction

    function automatic logic [63:0] therm(input int n);
        return (64'd1 << n) - 64'd1;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            pos = 0; wsum = 0; snap = 0; pend_s = 0; pend_e = 0; m_vld = 0;
            for (int i = 0; i < 2; i++) begin
                m_rate[i] = 0; m_show[i] = 0; peak[i] = 0; dec[i] = 0;
            end
        end else begin
            m_vld = 0;
            if (pend_e) begin
                pend_e = 0;
                for (int i = 0; i < 2; i++) begin
                    int lv;
                    lv = level_of(m_rate[i], cws[i]);
`ifdef CLUSTER_RATE_METER_PEAK_HOLD_EN
                    if (lv >= peak[i]) begin
                        peak[i] = lv; dec[i] = 0;
                    end else begin
                        dec[i]++;
                        if (dec[i] == DW) begin
                            peak[i] = (peak[i] - 1 > lv) ? peak[i] - 1 : lv;
                            dec[i]  = 0;
                        end
                    end
                    m_show[i] = peak[i];
`else
                    m_show[i] = lv;
`endif
                end
            end
            if (pend_s) begin
                pend_s = 0; pend_e = 1; m_vld = 1;
                for (int i = 0; i < 2; i++) begin
                    longint unsigned s, r;
                    s = (snap > full_scale(cws[i])) ? full_scale(cws[i]) : snap;
                    r = s * 16;
                    m_rate[i] = (r > full_scale(cws[i])) ? full_scale(cws[i]) : r;
                end
            end
            if (resync) begin
                pos = 0; wsum = 0;
            end else begin
                wsum += inc;
                if (pos == WINDOW - 1) begin
                    snap = wsum; pend_s = 1; wsum = 0; pos = 0;
                end else begin
                    pos++;
                end
            end
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            check("model_rate32", if32.rate_o,       m_rate[0]);
            check("model_vld32",  if32.rate_valid_o, m_vld);
            check("model_bar32",  if32.bar_o,        therm(m_show[0]));
            check("model_rate16", if16.rate_o,       m_rate[1]);
            check("model_vld16",  if16.rate_valid_o, m_vld);
            check("model_bar16",  if16.bar_o,        therm(m_show[1]));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_vld(inout int n, input int limit);
        while (!if32.rate_valid_o && n < limit) begin
            @(posedge clk); n++; @(negedge clk);
        end
    endtask

    // Reset with increment a for the first window, then b from the second
    // window on; returns the edge count from release to the first pulse.
    task automatic run_from_reset(input logic [7:0] a, input logic [7:0] b, output int n);
        rst = 1'b0; inc = a; resync = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1; n = 0;
        repeat (100) begin @(posedge clk); n++; end
        @(negedge clk);
        inc = b;
        wait_vld(n, 300);
    endtask

    logic [7:0] seq [5];

    initial begin
        int n;
`ifdef CLUSTER_RATE_METER_PEAK_HOLD_EN
        seq = '{8'h3F, 8'h3F, 8'h1F, 8'h1F, 8'h0F};
`else
        seq = '{8'h3F, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
        // Reset state
        repeat (3) @(negedge clk);
        check("reset_rate32", if32.rate_o, 0);
        check("reset_vld32",  if32.rate_valid_o, 0);
        check("reset_bar32",  if32.bar_o, 0);
        check("reset_rate16", if16.rate_o, 0);
        check("reset_bar16",  if16.bar_o, 0);

        // One cluster per BX: 100 * 16 = 1600 Hz, four decades
        run_from_reset(8'd1, 8'd1, n);
        check("first_pulse_latency", n, 101);
        check("inc1_rate32", if32.rate_o, 1600);
        check("inc1_rate16", if16.rate_o, 1600);
        @(posedge clk); @(negedge clk);
        check("inc1_bar32", if32.bar_o, 8'h0F);
        check("inc1_bar16", if16.bar_o, 8'h0F);

        // Resync in window cycle 50: edge 1 clears, window ends at edge 101,
        // pulse after edge 102; no pulse at the old boundary (edge 51).
        repeat (48) @(negedge clk);
        resync = 1'b1;
        @(posedge clk); n = 1;
        @(negedge clk); resync = 1'b0;
        check("resync_hold_rate32", if32.rate_o, 1600);
        wait_vld(n, 300);
        check("resync_pulse_delay", n, 102);
        check("resync_rate32", if32.rate_o, 1600);

        // Reset in the SCALE cycle of the following window aborts the update
        repeat (99) @(posedge clk);
        @(negedge clk);
        check("scale_pre_rate32", if32.rate_o, 1600);
        check("scale_pre_bar32",  if32.bar_o, 8'h0F);
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        check("abort_vld32",  if32.rate_valid_o, 0);
        check("abort_rate32", if32.rate_o, 0);
        check("abort_bar32",  if32.bar_o, 0);
        check("abort_rate16", if16.rate_o, 0);

        // 255 per BX for one window then silence: 408000 Hz / saturated 16-bit
        run_from_reset(8'd255, 8'd0, n);
        check("inc255_latency", n, 101);
        check("inc255_rate32", if32.rate_o, 408000);
        check("inc255_rate16", if16.rate_o, 16'hFFFF);
        @(posedge clk); @(negedge clk);
        check("decay_bar32_w0", if32.bar_o, seq[0]);
        check("inc255_bar16",   if16.bar_o, 8'h1F);
        for (int w = 1; w < 5; w++) begin
            n = 0;
            wait_vld(n, 200);
            check("window_period", n, 99);
            @(posedge clk); @(negedge clk);
            check($sformatf("decay_bar32_w%0d", w), if32.bar_o, seq[w]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
